// File: rtl/udp_tx_arbiter_pkg.sv
// Shared UDP TX definitions: arbiter state encoding, header field widths and header payload struct.
package udp_tx_arbiter_pkg;

    localparam int unsigned IP_W   = 32;
    localparam int unsigned PORT_W = 16;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [IP_W-1:0]   dest_ip;
        logic [PORT_W-1:0] source_port;
        logic [PORT_W-1:0] dest_port;
        logic [LEN_W-1:0]  length;
    } udp_hdr_t;

endpackage

// File: rtl/rr_priority_enc.sv
// Round-robin priority encoder: first asserted request at or after ptr, ascending with wrap.
module rr_priority_enc #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [2*N-1:0] rotated;
    logic [IW:0]    sum;

    // Rotating the doubled vector puts the ptr position at bit 0.
    assign rotated = {req, req} >> ptr;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!valid && rotated[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Frame-granular round-robin arbiter merging S_COUNT UDP TX header+payload streams into one.
module udp_tx_arbiter
    import udp_tx_arbiter_pkg::*;
#(
    parameter int unsigned S_COUNT   = 2,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned GRANT_W  = $clog2(S_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [S_COUNT-1:0]          s_udp_hdr_valid,
    output logic [S_COUNT-1:0]          s_udp_hdr_ready,
    input  logic [S_COUNT*IP_W-1:0]     s_udp_ip_dest_ip,
    input  logic [S_COUNT*PORT_W-1:0]   s_udp_source_port,
    input  logic [S_COUNT*PORT_W-1:0]   s_udp_dest_port,
    input  logic [S_COUNT*LEN_W-1:0]    s_udp_length,
    input  logic [S_COUNT*DATA_W-1:0]   s_udp_payload_axis_tdata,
    input  logic [S_COUNT-1:0]          s_udp_payload_axis_tvalid,
    input  logic [S_COUNT-1:0]          s_udp_payload_axis_tlast,
    input  logic [S_COUNT-1:0]          s_udp_payload_axis_tuser,
    output logic [S_COUNT-1:0]          s_udp_payload_axis_tready,

    output logic                        m_udp_hdr_valid,
    input  logic                        m_udp_hdr_ready,
    output logic [IP_W-1:0]             m_udp_ip_dest_ip,
    output logic [PORT_W-1:0]           m_udp_source_port,
    output logic [PORT_W-1:0]           m_udp_dest_port,
    output logic [LEN_W-1:0]            m_udp_length,
    output logic [DATA_W-1:0]           m_udp_payload_axis_tdata,
    output logic                        m_udp_payload_axis_tvalid,
    output logic                        m_udp_payload_axis_tlast,
    output logic                        m_udp_payload_axis_tuser,
    input  logic                        m_udp_payload_axis_tready,

    output logic [GRANT_W-1:0]          grant_id,
    output logic                        busy,
    output logic [CNT_WIDTH-1:0]        frames_sent
);

    arb_state_t           state, state_nxt;
    logic [GRANT_W-1:0]   grant_nxt;
    logic [GRANT_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_WIDTH-1:0] frames_nxt;
    logic [GRANT_W-1:0]   enc_idx;
    logic                 enc_valid;

    udp_hdr_t             sel_hdr;
    logic                 sel_hdr_valid;
    logic [DATA_W-1:0]    sel_tdata;
    logic                 sel_tvalid;
    logic                 sel_tlast;
    logic                 sel_tuser;
    logic                 hdr_fire;
    logic                 frame_done;

    rr_priority_enc #(
        .N  (S_COUNT),
        .IW (GRANT_W)
    ) u_rr_priority_enc (
        .req   (s_udp_hdr_valid),
        .ptr   (rr_ptr),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Select the granted requester's header and payload slices.
    always_comb begin
        sel_hdr       = '0;
        sel_hdr_valid = 1'b0;
        sel_tdata     = '0;
        sel_tvalid    = 1'b0;
        sel_tlast     = 1'b0;
        sel_tuser     = 1'b0;
        for (int unsigned i = 0; i < S_COUNT; i++) begin
            if (grant_id == GRANT_W'(i)) begin
                sel_hdr.dest_ip     = s_udp_ip_dest_ip[i*IP_W +: IP_W];
                sel_hdr.source_port = s_udp_source_port[i*PORT_W +: PORT_W];
                sel_hdr.dest_port   = s_udp_dest_port[i*PORT_W +: PORT_W];
                sel_hdr.length      = s_udp_length[i*LEN_W +: LEN_W];
                sel_hdr_valid       = s_udp_hdr_valid[i];
                sel_tdata           = s_udp_payload_axis_tdata[i*DATA_W +: DATA_W];
                sel_tvalid          = s_udp_payload_axis_tvalid[i];
                sel_tlast           = s_udp_payload_axis_tlast[i];
                sel_tuser           = s_udp_payload_axis_tuser[i];
            end
        end
    end

    // Upstream readies: only the owner sees the downstream ready, and only in its phase.
    always_comb begin
        s_udp_hdr_ready           = '0;
        s_udp_payload_axis_tready = '0;
        for (int unsigned i = 0; i < S_COUNT; i++) begin
            if (grant_id == GRANT_W'(i)) begin
                s_udp_hdr_ready[i]           = (state == ST_HDR) && m_udp_hdr_ready;
                s_udp_payload_axis_tready[i] = (state == ST_PAYLOAD) && m_udp_payload_axis_tready;
            end
        end
    end

    assign m_udp_hdr_valid           = (state == ST_HDR) && sel_hdr_valid;
    assign m_udp_ip_dest_ip          = sel_hdr.dest_ip;
    assign m_udp_source_port         = sel_hdr.source_port;
    assign m_udp_dest_port           = sel_hdr.dest_port;
    assign m_udp_length              = sel_hdr.length;
    assign m_udp_payload_axis_tvalid = (state == ST_PAYLOAD) && sel_tvalid;
    assign m_udp_payload_axis_tdata  = sel_tdata;
    assign m_udp_payload_axis_tlast  = sel_tlast;
    assign m_udp_payload_axis_tuser  = sel_tuser;

    assign hdr_fire   = m_udp_hdr_valid && m_udp_hdr_ready;
    assign frame_done = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready && sel_tlast;

    // Next-state logic; the grant is held from IDLE until the tlast beat of the frame.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_id;
        rr_ptr_nxt = rr_ptr;
        frames_nxt = frames_sent;
        case (state)
            ST_IDLE: begin
                if (enc_valid) begin
                    grant_nxt = enc_idx;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_fire) begin
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (frame_done) begin
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = (grant_id == GRANT_W'(S_COUNT-1)) ? '0 : grant_id + GRANT_W'(1);
                    frames_nxt = frames_sent + CNT_WIDTH'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            rr_ptr      <= '0;
            frames_sent <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_nxt;
            rr_ptr      <= rr_ptr_nxt;
            frames_sent <= frames_nxt;
            busy        <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized self-checking bench for udp_tx_arbiter against a frame-level round-robin model.
module tb_udp_tx_arbiter;

    localparam int unsigned S      = 3;
    localparam int unsigned CW     = 8;
    localparam int unsigned IW     = $clog2(S);
    localparam int unsigned MAXLEN = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [S-1:0]      s_udp_hdr_valid, s_udp_hdr_ready;
    logic [32*S-1:0]   s_udp_ip_dest_ip;
    logic [16*S-1:0]   s_udp_source_port, s_udp_dest_port, s_udp_length;
    logic [8*S-1:0]    s_udp_payload_axis_tdata;
    logic [S-1:0]      s_udp_payload_axis_tvalid, s_udp_payload_axis_tlast;
    logic [S-1:0]      s_udp_payload_axis_tuser, s_udp_payload_axis_tready;
    logic              m_udp_hdr_valid, m_udp_hdr_ready;
    logic [31:0]       m_udp_ip_dest_ip;
    logic [15:0]       m_udp_source_port, m_udp_dest_port, m_udp_length;
    logic [7:0]        m_udp_payload_axis_tdata;
    logic              m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast;
    logic              m_udp_payload_axis_tuser, m_udp_payload_axis_tready;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic [CW-1:0]     frames_sent;

    udp_tx_arbiter #(.S_COUNT(S), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
        .s_udp_ip_dest_ip(s_udp_ip_dest_ip), .s_udp_source_port(s_udp_source_port),
        .s_udp_dest_port(s_udp_dest_port), .s_udp_length(s_udp_length),
        .s_udp_payload_axis_tdata(s_udp_payload_axis_tdata),
        .s_udp_payload_axis_tvalid(s_udp_payload_axis_tvalid),
        .s_udp_payload_axis_tlast(s_udp_payload_axis_tlast),
        .s_udp_payload_axis_tuser(s_udp_payload_axis_tuser),
        .s_udp_payload_axis_tready(s_udp_payload_axis_tready),
        .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
        .m_udp_ip_dest_ip(m_udp_ip_dest_ip), .m_udp_source_port(m_udp_source_port),
        .m_udp_dest_port(m_udp_dest_port), .m_udp_length(m_udp_length),
        .m_udp_payload_axis_tdata(m_udp_payload_axis_tdata),
        .m_udp_payload_axis_tvalid(m_udp_payload_axis_tvalid),
        .m_udp_payload_axis_tlast(m_udp_payload_axis_tlast),
        .m_udp_payload_axis_tuser(m_udp_payload_axis_tuser),
        .m_udp_payload_axis_tready(m_udp_payload_axis_tready),
        .grant_id(grant_id), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester sources: one frame in flight each, frames_left queued behind it.
    int          frames_left [S];
    bit          hdr_done    [S];
    int          tx_idx      [S];
    int          len         [S];
    logic [31:0] ip          [S];
    logic [15:0] sp          [S];
    logic [15:0] dp          [S];
    logic [7:0]  data        [S][MAXLEN];

    int fixed_len, hdr_ready_mode, tready_mode;
    bit hdr_gaps, tvalid_gaps, tog;

    // Frame-level reference: who owns the output, where round-robin resumes, frames done.
    bit    m_busy, m_hdr_acc;
    int    m_owner, m_ptr, m_idx, m_count;
    int    err, early_cnt;
    string last_err;
    int          order_q[$];
    logic [7:0]  out_q[$];
    logic [31:0] cap_ip;
    logic [15:0] cap_sp, cap_dp, cap_len;

    function automatic int rr_pick(input logic [S-1:0] v, input int p);
        for (int k = 0; k < S; k++) begin
            if (v[(p + k) % S]) return (p + k) % S;
        end
        return 0;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < S; i++) if (frames_left[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic new_frame(input int i);
        len[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, MAXLEN));
        ip[i]  = $urandom;
        sp[i]  = 16'($urandom);
        dp[i]  = 16'($urandom);
        for (int k = 0; k < MAXLEN; k++) data[i][k] = 8'($urandom);
    endtask

    task automatic load(input int i, input int n);
        frames_left[i] = n;
        hdr_done[i]    = 1'b0;
        tx_idx[i]      = 0;
        new_frame(i);
    endtask

    task automatic clear_all();
        for (int i = 0; i < S; i++) begin
            frames_left[i] = 0; hdr_done[i] = 1'b0; tx_idx[i] = 0; len[i] = 1;
            ip[i] = '0; sp[i] = '0; dp[i] = '0;
            for (int k = 0; k < MAXLEN; k++) data[i][k] = '0;
        end
        m_busy = 1'b0; m_hdr_acc = 1'b0; m_owner = 0; m_ptr = 0; m_idx = 0; m_count = 0;
        order_q.delete(); out_q.delete(); early_cnt = 0;
    endtask

    task automatic knobs(input int flen, input int hmode, input int tmode, input bit hg, input bit tg);
        fixed_len = flen; hdr_ready_mode = hmode; tready_mode = tmode;
        hdr_gaps = hg; tvalid_gaps = tg; tog = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < S; i++) begin
            s_udp_ip_dest_ip[i*32 +: 32]  = ip[i];
            s_udp_source_port[i*16 +: 16] = sp[i];
            s_udp_dest_port[i*16 +: 16]   = dp[i];
            s_udp_length[i*16 +: 16]      = 16'(len[i] + 8);
            s_udp_hdr_valid[i] = (frames_left[i] > 0) && !hdr_done[i] &&
                                 (!hdr_gaps || $urandom_range(0, 2) != 0);
            s_udp_payload_axis_tvalid[i] = (frames_left[i] > 0) && (tx_idx[i] < len[i]) &&
                                           (!tvalid_gaps || $urandom_range(0, 2) != 0);
            s_udp_payload_axis_tdata[i*8 +: 8] = data[i][tx_idx[i]];
            s_udp_payload_axis_tlast[i] = (tx_idx[i] == len[i] - 1);
            s_udp_payload_axis_tuser[i] = ^data[i][tx_idx[i]];
        end
        m_udp_hdr_ready = (hdr_ready_mode == 0) ? 1'b1 :
                          (hdr_ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (tready_mode == 0)      m_udp_payload_axis_tready = 1'b1;
        else if (tready_mode == 1) m_udp_payload_axis_tready = 1'($urandom_range(0, 1));
        else begin
            m_udp_payload_axis_tready = tog;
            tog = ~tog;
        end
    endtask

    // One clock: sample at negedge, check against the model, advance model and sources, drive.
    task automatic step();
        logic [S-1:0] exp_hr, exp_tr;
        @(negedge clk);
        exp_hr = '0;
        exp_tr = '0;
        if (busy !== m_busy) begin err++; last_err = "busy"; end
        if (frames_sent !== CW'(m_count)) begin err++; last_err = "frames_sent"; end
        if (!m_busy) begin
            if (m_udp_hdr_valid !== 1'b0 || m_udp_payload_axis_tvalid !== 1'b0) begin
                err++; last_err = "valid while idle";
            end
        end else begin
            if (grant_id !== IW'(m_owner)) begin err++; last_err = "grant_id"; end
            if (!m_hdr_acc) begin
                exp_hr[m_owner] = m_udp_hdr_ready;
                if (m_udp_hdr_valid !== s_udp_hdr_valid[m_owner]) begin err++; last_err = "hdr_valid"; end
                if (m_udp_ip_dest_ip !== ip[m_owner] || m_udp_source_port !== sp[m_owner] ||
                    m_udp_dest_port !== dp[m_owner] || m_udp_length !== 16'(len[m_owner] + 8)) begin
                    err++; last_err = "hdr fields";
                end
                if (m_udp_payload_axis_tvalid !== 1'b0) begin err++; last_err = "tvalid in hdr"; end
            end else begin
                exp_tr[m_owner] = m_udp_payload_axis_tready;
                if (m_udp_hdr_valid !== 1'b0) begin err++; last_err = "hdr_valid in payload"; end
                if (m_udp_payload_axis_tvalid !== s_udp_payload_axis_tvalid[m_owner]) begin
                    err++; last_err = "tvalid";
                end
            end
        end
        if (s_udp_hdr_ready !== exp_hr) begin err++; last_err = "s_hdr_ready"; end
        if (s_udp_payload_axis_tready !== exp_tr) begin err++; last_err = "s_tready"; end
        for (int i = 0; i < S; i++) begin
            if (s_udp_payload_axis_tready[i] && !hdr_done[i]) early_cnt++;
        end
        if (m_udp_hdr_valid && m_udp_hdr_ready) begin
            order_q.push_back(int'(grant_id));
            cap_ip = m_udp_ip_dest_ip; cap_sp = m_udp_source_port;
            cap_dp = m_udp_dest_port;  cap_len = m_udp_length;
        end
        if (m_udp_payload_axis_tvalid && m_udp_payload_axis_tready) out_q.push_back(m_udp_payload_axis_tdata);

        if (!m_busy) begin
            if (|s_udp_hdr_valid) begin
                m_owner = rr_pick(s_udp_hdr_valid, m_ptr);
                m_busy = 1'b1; m_hdr_acc = 1'b0; m_idx = 0;
            end
        end else if (!m_hdr_acc) begin
            if (s_udp_hdr_valid[m_owner] && m_udp_hdr_ready) m_hdr_acc = 1'b1;
        end else if (s_udp_payload_axis_tvalid[m_owner] && m_udp_payload_axis_tready) begin
            if (m_udp_payload_axis_tdata !== data[m_owner][m_idx] ||
                m_udp_payload_axis_tlast !== (m_idx == len[m_owner] - 1) ||
                m_udp_payload_axis_tuser !== ^data[m_owner][m_idx]) begin
                err++; last_err = "payload beat";
            end
            m_idx++;
            if (m_idx >= len[m_owner]) begin
                m_count++;
                m_ptr  = (m_owner + 1) % S;
                m_busy = 1'b0;
            end
        end

        for (int i = 0; i < S; i++) begin
            if (s_udp_hdr_valid[i] && s_udp_hdr_ready[i]) hdr_done[i] = 1'b1;
            if (s_udp_payload_axis_tvalid[i] && s_udp_payload_axis_tready[i] && frames_left[i] > 0) begin
                tx_idx[i]++;
                if (tx_idx[i] >= len[i]) begin
                    frames_left[i]--; hdr_done[i] = 1'b0; tx_idx[i] = 0;
                    if (frames_left[i] > 0) new_frame(i);
                end
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while ((pending() || m_busy) && n < budget) begin
            step();
            n++;
        end
        if (pending() || m_busy) begin
            total++; bad++;
            $display("FAIL %s_timeout: frames still pending after %0d cycles, required all done", name, budget);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic test_reset();
        clear_all();
        knobs(4, 0, 0, 1'b0, 1'b0);
        load(0, 1); load(1, 1); load(2, 1);
        drive();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant_id !== '0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        total++; if (frames_sent !== '0) begin bad++; $display("FAIL reset_frames: got %0d want 0", frames_sent); end
        total++; if (s_udp_hdr_ready !== '0) begin bad++; $display("FAIL reset_hdr_ready: got %b want 0", s_udp_hdr_ready); end
        total++; if (s_udp_payload_axis_tready !== '0) begin
            bad++; $display("FAIL reset_tready: got %b want 0", s_udp_payload_axis_tready);
        end
        total++; if ({m_udp_hdr_valid, m_udp_payload_axis_tvalid} !== 2'b00) begin
            bad++; $display("FAIL reset_m_valid: got %b%b want 00", m_udp_hdr_valid, m_udp_payload_axis_tvalid);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [31:0] e_ip;
        logic [15:0] e_sp, e_dp;
        logic [7:0]  e_b[MAXLEN];
        bit          same;
        err = 0;
        do_reset();
        knobs(10, 0, 0, 1'b0, 1'b0);
        load(1, 1);
        e_ip = ip[1]; e_sp = sp[1]; e_dp = dp[1];
        for (int k = 0; k < MAXLEN; k++) e_b[k] = data[1][k];
        drive();
        run_until_done(100, "single");
        total++; if (order_q.size() != 1 || order_q[0] != 1) begin
            bad++; $display("FAIL single_grant: got n=%0d id=%0d want n=1 id=1", order_q.size(), order_q[0]);
        end
        total++; if (cap_ip !== e_ip || cap_sp !== e_sp || cap_dp !== e_dp || cap_len !== 16'd18) begin
            bad++; $display("FAIL single_hdr: got %h/%h/%h/%0d want %h/%h/%h/18", cap_ip, cap_sp, cap_dp, cap_len, e_ip, e_sp, e_dp);
        end
        same = (out_q.size() == 10);
        for (int k = 0; k < 10 && same; k++) if (out_q[k] !== e_b[k]) same = 1'b0;
        total++; if (!same) begin bad++; $display("FAIL single_payload: got %0d beats or wrong data, want 10 in order", out_q.size()); end
        total++; if (frames_sent !== CW'(1)) begin bad++; $display("FAIL single_count: got %0d want 1", frames_sent); end
        total++; if (err != 0) begin bad++; $display("FAIL single_protocol: got %0d errors (%s) want 0", err, last_err); end
    endtask

    task automatic test_rr_order();
        int exp_ord[4] = '{0, 1, 0, 1};
        int miss = 0;
        int reps = 0;
        err = 0;
        do_reset();
        knobs(0, 0, 0, 1'b0, 1'b0);
        load(0, 2); load(1, 2);
        drive();
        run_until_done(300, "rr");
        for (int k = 0; k < 4; k++) if (k >= order_q.size() || order_q[k] != exp_ord[k]) miss++;
        for (int k = 1; k < order_q.size(); k++) if (order_q[k] == order_q[k-1]) reps++;
        total++; if (miss != 0 || order_q.size() != 4) begin
            bad++; $display("FAIL rr_order: got %0d frames with %0d misplaced, want 0,1,0,1", order_q.size(), miss);
        end
        total++; if (reps != 0) begin bad++; $display("FAIL rr_repeat: got %0d back-to-back repeats want 0", reps); end
        total++; if (err != 0) begin bad++; $display("FAIL rr_protocol: got %0d errors (%s) want 0", err, last_err); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e_b[MAXLEN];
        bit         same;
        err = 0;
        clear_all();
        do_reset();
        knobs(4, 0, 2, 1'b0, 1'b0);
        load(0, 1);
        for (int k = 0; k < MAXLEN; k++) e_b[k] = data[0][k];
        drive();
        run_until_done(100, "bp");
        same = (out_q.size() == 4);
        for (int k = 0; k < 4 && same; k++) if (out_q[k] !== e_b[k]) same = 1'b0;
        total++; if (!same) begin bad++; $display("FAIL bp_payload: got %0d beats or wrong data, want 4 in order", out_q.size()); end
        total++; if (err != 0) begin bad++; $display("FAIL bp_protocol: got %0d errors (%s) want 0", err, last_err); end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        err = 0;
        do_reset();
        knobs(2, 0, 0, 1'b0, 1'b0);
        load(0, 1);
        drive();
        run_until_done(50, "mid_pre");
        knobs(8, 0, 0, 1'b0, 1'b0);
        load(1, 1);
        drive();
        while (tx_idx[1] < 2 && n < 50) begin step(); n++; end
        total++; if (tx_idx[1] != 2) begin bad++; $display("FAIL mid_reach: got %0d beats want 2 before reset", tx_idx[1]); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, m_udp_hdr_valid, m_udp_payload_axis_tvalid} !== 3'b000 ||
                     s_udp_hdr_ready !== '0 || s_udp_payload_axis_tready !== '0 ||
                     grant_id !== '0 || frames_sent !== '0) begin
            bad++; $display("FAIL mid_reset_outputs: got busy=%b hv=%b tv=%b gid=%0d cnt=%0d want all 0",
                            busy, m_udp_hdr_valid, m_udp_payload_axis_tvalid, grant_id, frames_sent);
        end
        do_reset();
        knobs(3, 0, 0, 1'b0, 1'b0);
        load(0, 1); load(1, 1);
        drive();
        run_until_done(100, "mid_post");
        total++; if (order_q.size() != 2 || order_q[0] != 0 || order_q[1] != 1) begin
            bad++; $display("FAIL mid_restart_order: got n=%0d first=%0d want 0 then 1", order_q.size(), order_q[0]);
        end
        total++; if (err != 0) begin bad++; $display("FAIL mid_protocol: got %0d errors (%s) want 0", err, last_err); end
    endtask

    task automatic test_early_payload();
        err = 0;
        do_reset();
        knobs(1, 2, 0, 1'b0, 1'b0);
        load(1, 1);
        drive();
        repeat (6) step();
        total++; if (tx_idx[1] != 0 || early_cnt != 0) begin
            bad++; $display("FAIL early_stall: got consumed=%0d early_ready=%0d want 0/0", tx_idx[1], early_cnt);
        end
        hdr_ready_mode = 0;
        run_until_done(50, "early");
        total++; if (out_q.size() != 1 || early_cnt != 0) begin
            bad++; $display("FAIL early_deliver: got beats=%0d early_ready=%0d want 1/0", out_q.size(), early_cnt);
        end
        total++; if (err != 0) begin bad++; $display("FAIL early_protocol: got %0d errors (%s) want 0", err, last_err); end
    endtask

    task automatic test_random();
        int sum = 0;
        int f0;
        err = 0;
        order_q.delete();
        knobs(0, 1, 1, 1'b1, 1'b1);
        f0 = int'(frames_sent);
        for (int i = 0; i < S; i++) begin
            int n = int'($urandom_range(1, 4));
            load(i, n);
            sum += n;
        end
        drive();
        run_until_done(6000, "random");
        total++; if (frames_sent !== CW'(f0 + sum) || order_q.size() != sum) begin
            bad++; $display("FAIL random_frames: got cnt=%0d hdrs=%0d want cnt=%0d hdrs=%0d",
                            frames_sent, order_q.size(), CW'(f0 + sum), sum);
        end
        total++; if (err != 0 || early_cnt != 0) begin
            bad++; $display("FAIL random_protocol: got %0d errors (%s) early=%0d want 0", err, last_err, early_cnt);
        end
    endtask

    task automatic test_wrap();
        err = 0;
        do_reset();
        knobs(1, 0, 0, 1'b0, 1'b0);
        load(2, 255);
        drive();
        run_until_done(2000, "wrap_pre");
        total++; if (frames_sent !== 8'd255) begin bad++; $display("FAIL wrap_full: got %0d want 255", frames_sent); end
        load(2, 1);
        drive();
        run_until_done(20, "wrap");
        total++; if (frames_sent !== 8'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", frames_sent); end
        total++; if (err != 0) begin bad++; $display("FAIL wrap_protocol: got %0d errors (%s) want 0", err, last_err); end
    endtask

    initial begin
        last_err = "none";
        test_reset();
        test_single();
        test_rr_order();
        test_backpressure();
        test_reset_midframe();
        test_early_payload();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
